// File: rtl/fcvt_s_w_iter.sv
// Multi-cycle int32 -> IEEE-754 single converter (FCVT.S.W / FCVT.S.WU).
// Iterative leading-zero normalisation, one rounding cycle, valid/ready on both sides.
module fcvt_s_w_iter #(
  parameter int unsigned NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_z,
  output logic        fflag_nx
);

  typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

  localparam logic [7:0] StepExp = 8'(NORM_STEP);

  state_e      state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [2:0]  rm_q;
  logic [7:0]  exp_q;

  logic        sign_in;
  logic [31:0] mag_in;
  logic        top_zero;
  logic [22:0] frac;
  logic        guard, sticky, inc;
  logic [23:0] frac_sum;
  logic [7:0]  exp_biased;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_comb begin
    sign_in  = ~is_unsigned & input_a[31];
    // Two's complement negation also maps 0x80000000 onto itself as an unsigned magnitude.
    mag_in   = sign_in ? (~input_a + 32'd1) : input_a;
    top_zero = (mag_q[31 -: NORM_STEP] == '0);
  end

  always_comb begin
    frac   = mag_q[30:8];
    guard  = mag_q[7];
    sticky = |mag_q[6:0];
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = (guard | sticky) & sign_q;
      3'b011:  inc = (guard | sticky) & ~sign_q;
      3'b100:  inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase
    frac_sum   = {1'b0, frac} + {23'b0, inc};
    exp_biased = exp_q + 8'd127 + {7'b0, frac_sum[23]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      rm_q     <= '0;
      exp_q    <= '0;
      output_z <= '0;
      fflag_nx <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q <= sign_in;
            mag_q  <= mag_in;
            rm_q   <= rm;
            exp_q  <= 8'd31;
            if (mag_in == '0) begin
              output_z <= '0;
              fflag_nx <= 1'b0;
              state_q  <= StDone;
            end else begin
              state_q <= StNorm;
            end
          end
        end
        StNorm: begin
          if (mag_q[31]) begin
            state_q <= StRound;
          end else if (top_zero) begin
            mag_q <= mag_q << NORM_STEP;
            exp_q <= exp_q - StepExp;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        StRound: begin
          // A carry out of the fraction leaves it all-zero with the exponent bumped.
          output_z <= {sign_q, exp_biased, frac_sum[22:0]};
          fflag_nx <= guard | sticky;
          state_q  <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_s_w_iter.sv
// Bench for fcvt_s_w_iter: two instances (NORM_STEP 1 and 8) checked against an
// arithmetic integer-to-float model, plus directed handshake, flush and reset steps.
module tb_fcvt_s_w_iter;

  logic        clk = 1'b0;
  logic        rst_n, flush, out_ready;
  logic        in_valid1, in_valid8;
  logic [31:0] input_a;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic        ir1, ov1, nx1, ir8, ov8, nx8;
  logic [31:0] z1, z8;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  fcvt_s_w_iter #(.NORM_STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(ir1),
    .input_a(input_a), .is_unsigned(is_unsigned), .rm(rm), .out_valid(ov1),
    .out_ready(out_ready), .output_z(z1), .fflag_nx(nx1)
  );

  fcvt_s_w_iter #(.NORM_STEP(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid8), .in_ready(ir8),
    .input_a(input_a), .is_unsigned(is_unsigned), .rm(rm), .out_valid(ov8),
    .out_ready(out_ready), .output_z(z8), .fflag_nx(nx8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value of the integer, rounded by comparing the discarded remainder with one half ulp.
  function automatic void model(input logic [31:0] a, input logic u, input logic [2:0] r,
                                input int ns, output logic [31:0] z, output logic nx,
                                output int lat);
    longint unsigned m, q, rem, half;
    int e, k, lz;
    logic sg, inc;
    sg = !u && a[31];
    m  = sg ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
    if (m == 0) begin
      z = '0; nx = 1'b0; lat = 1;
      return;
    end
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    lz = 31 - e;
    if (e <= 23) begin
      q = m << (23 - e); rem = 0; half = 1;
    end else begin
      k = e - 23; q = m >> k; rem = m - (q << k); half = 64'd1 << (k - 1);
    end
    case (r)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (rem != 0) && sg;
      3'd3:    inc = (rem != 0) && !sg;
      3'd4:    inc = (rem != 0) && (rem >= half);
      default: inc = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + {63'b0, inc};
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23; e++;
    end
    z   = {sg, 8'(e + 127), q[22:0]};
    nx  = (rem != 0);
    lat = 3 + lz / ns + lz % ns;
  endfunction

  // One conversion on the chosen instance; holds out_ready low for 'hold' cycles in DONE.
  task automatic run(input bit s8, input logic [31:0] a, input logic u, input logic [2:0] r,
                     input int hold, input string tag);
    logic [31:0] ez;
    logic        enx;
    int          elat, lat;
    model(a, u, r, s8 ? 8 : 1, ez, enx, elat);
    input_a = a; is_unsigned = u; rm = r;
    if (s8) in_valid8 = 1'b1; else in_valid1 = 1'b1;
    chk({tag, " in_ready"}, {31'b0, s8 ? ir8 : ir1}, 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    input_a = $urandom; is_unsigned = 1'($urandom); rm = 3'($urandom);
    lat = 1;
    while (!(s8 ? ov8 : ov1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " z"}, s8 ? z8 : z1, ez);
    chk({tag, " nx"}, {31'b0, s8 ? nx8 : nx1}, {31'b0, enx});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold z"}, s8 ? z8 : z1, ez);
      chk({tag, " hold nx"}, {31'b0, s8 ? nx8 : nx1}, {31'b0, enx});
      chk({tag, " hold in_ready"}, {31'b0, s8 ? ir8 : ir1}, 32'd0);
      chk({tag, " hold out_valid"}, {31'b0, s8 ? ov8 : ov1}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " back idle"}, {30'b0, s8 ? ir8 : ir1, s8 ? ov8 : ov1}, 32'd2);
  endtask

  // Starts a long conversion, aborts it mid-NORM with flush or reset, checks nothing emerges.
  task automatic abort(input bit use_rst, input string tag);
    int highs;
    input_a = 32'd1; is_unsigned = 1'b0; rm = 3'd0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (use_rst) rst_n = 1'b0; else flush = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0;
    chk({tag, " idle"}, {30'b0, ir1, ov1}, 32'd2);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov1 || !ir1) highs++;
    end
    chk({tag, " stays idle"}, 32'(highs), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    input_a = '0; is_unsigned = 1'b0; rm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset z1", z1, 32'd0);
    chk("reset z8", z8, 32'd0);
    chk("reset flags1", {29'b0, ir1, ov1, nx1}, 32'd4);
    chk("reset flags8", {29'b0, ir8, ov8, nx8}, 32'd4);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 32'h0000_0001, 0, 3'd0, 0, "one s1");
    run(1, 32'h0000_0001, 0, 3'd0, 0, "one s8");
    run(0, 32'hFFFF_FFFF, 0, 3'd0, 0, "m1 signed");
    run(0, 32'hFFFF_FFFF, 1, 3'd0, 0, "ffff rne");
    run(0, 32'hFFFF_FFFF, 1, 3'd1, 0, "ffff rtz");
    run(0, 32'h8000_0000, 0, 3'd0, 0, "min signed");
    run(0, 32'h8000_0000, 1, 3'd0, 0, "min unsigned");
    run(0, 32'h0000_0000, 0, 3'd3, 0, "zero");
    run(0, 32'h0100_0001, 1, 3'd0, 0, "tie rne");
    run(0, 32'h0100_0001, 1, 3'd3, 0, "tie rup");
    run(0, 32'h0100_0001, 1, 3'd4, 0, "tie rmm");
    run(0, 32'h0100_0001, 1, 3'd2, 0, "tie rdn");
    run(0, 32'hFEFF_FFFF, 0, 3'd2, 0, "neg rdn");
    run(0, 32'h0123_4567, 0, 3'd6, 5, "hold");
    run(1, 32'h0000_0000, 1, 3'd0, 0, "zero s8");

    // flush beats a same-cycle accept
    input_a = 32'h0000_0000; in_valid1 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; flush = 1'b0;
    chk("flush vs accept", {30'b0, ir1, ov1}, 32'd2);

    // flush discards a result waiting in DONE
    input_a = 32'h0000_0000; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("done before flush", {31'b0, ov1}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in done", {30'b0, ir1, ov1}, 32'd2);

    abort(0, "flush norm");
    run(0, 32'h7FFF_FFC0, 0, 3'd0, 0, "after flush");
    abort(1, "reset norm");
    run(0, 32'h0000_0003, 1, 3'd1, 0, "after reset");

    for (int i = 0; i < 60; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if (($urandom & 7) == 0) a = ~a;
      run(1'(i & 1), a, 1'($urandom), 3'($urandom), 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
